one_to_n_distributor: RTL and testbench
=======================================

Name: one_to_n_distributor

Overview:
- Splits one flit stream into N output streams; the inverse of the N-to-1 priority reductor on the same avail/valid flit interface.
- Decodes the destination field of each HEAD_FLIT or SINGLE_FLIT and locks the route until the TAIL_FLIT.
- Buffers each output in a small FIFO so one stalled port does not corrupt packet framing.
- Sits at a router output stage, feeding per-port reductors or link drivers.

Parameters:
- N, 6, number of output ports.
- DST_W, 3, width of the destination field; N ≤ 2^DST_W.
- DST_POS, FLIT_SIZE-HEADER_LEN-1, MSB position of the destination field; field is [DST_POS : DST_POS-DST_W+1].
- FIFO_DEPTH, 2, entries per output FIFO (≥1).
- FLIT_SIZE, HEADER_LEN, HEAD_FLIT, BODY_FLIT, TAIL_FLIT and SINGLE_FLIT come from the shared para.sv include.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in  input  FLIT_SIZE  incoming flit.
- in_valid  input  1  in carries a flit.
- in_avail  output  1  block accepts a flit this cycle.
- out  output  FLIT_SIZE*N  port i flit at [FLIT_SIZE*i+FLIT_SIZE-1 : FLIT_SIZE*i].
- out_valid  output  N  port i FIFO non-empty.
- out_avail  input  N  downstream port i accepts this cycle.
- drop_err  output  1  one-cycle pulse: a flit was discarded.

Behaviour:
- Flit type is in[FLIT_SIZE-1 : FLIT_SIZE-HEADER_LEN]. Transfers occur at posedge when valid && avail, on both sides.
- Input slot: one register plus slot_valid.
  - in_avail = !rst && (!slot_valid || slot_pop), combinational.
  - On an accepted flit, the slot loads in and slot_valid is set; otherwise slot_valid clears when the slot pops.
- slot_pop = slot_valid && (flit is discarded || target FIFO can push).
- A FIFO can push when it is not full, or when it is full and popping this cycle (same-cycle push/pop on a full FIFO is legal).
- Latency: flit accepted at edge t sits in the slot during cycle t+1. It is pushed at edge t+1 and visible on out/out_valid from cycle t+2. Throughput is 1 flit/cycle with no stalls.
- dst = slot[DST_POS : DST_POS-DST_W+1]; dst ≥ N is out of range.
- FSM states IDLE, ROUTE (locked port cur), DROP. All transitions happen only when slot_pop.
  - IDLE + SINGLE, dst valid: push to FIFO[dst]; stay IDLE.
  - IDLE + HEAD, dst valid: push to FIFO[dst]; cur←dst; go to ROUTE.
  - IDLE + SINGLE, dst ≥ N: discard; pulse drop_err; stay IDLE.
  - IDLE + HEAD, dst ≥ N: discard; pulse drop_err; go to DROP.
  - IDLE + BODY/TAIL (orphan): discard; pulse drop_err.
  - ROUTE + BODY: push to FIFO[cur].
  - ROUTE + TAIL: push to FIFO[cur]; go to IDLE.
  - ROUTE + HEAD/SINGLE (framing violation): pulse drop_err. The open packet is implicitly closed and the flit is then handled exactly as in IDLE, same cycle.
  - DROP: discard every flit; on TAIL return to IDLE. drop_err pulses only on entry to DROP, not per flit.
- While in ROUTE, flits never go to any port other than cur, even if that FIFO is full; the slot simply stalls.
- Output FIFOs: out slice i = FIFO[i] head entry, 0 when empty. Pop when out_valid[i] && out_avail[i]. Ports are fully independent; a full port stalls only flits destined to it.
- drop_err is registered: asserted the cycle after the discarding slot_pop.
- Reset: state←IDLE, slot_valid←0, slot←0, all FIFO pointers/counts←0, out_valid←0, out←0, drop_err←0, in_avail←0 while rst=1.
- Reset mid-packet abandons all buffered and in-flight flits with no error pulse. in_avail returns high in the first cycle after rst falls.

Test Plan:
- SINGLE, dst=3, all out_avail=1, accepted at edge t: out_valid=6'b001000 at t+2 with the same flit on slice 3; other slices 0.
- HEAD dst=1, two BODY, TAIL dst field=4, back-to-back: all four flits on port 1 in order on consecutive cycles; FSM returns to IDLE; no traffic on port 4.
- 4-flit packet to port 2 with out_avail[2]=0 (FIFO_DEPTH=2): after 2 pushes plus the slot holding the third flit, in_avail=0. Raising out_avail[2] drains in order. A following SINGLE to port 0 waits behind the packet.
- HEAD dst=7 (N=6), BODY, TAIL, then SINGLE dst=0: single drop_err pulse; no out_valid for the dropped packet; the SINGLE appears on port 0.
- Orphan BODY in IDLE: drop_err pulse, no output. HEAD dst=2 then HEAD dst=5 without TAIL: drop_err pulse and the second packet routes to port 5.
- rst asserted while in ROUTE with flits buffered: next cycle out_valid=0, in_avail=0. After release, a SINGLE dst=0 routes normally.

Source files
------------

// File: rtl/one_to_n_distributor.sv
// one_to_n_distributor
// Splits a single flit stream into N output streams. The destination field of
// each HEAD or SINGLE flit selects the port; a HEAD locks that port until the
// matching TAIL. Each port has its own small FIFO, so a stalled port only holds
// back flits that are headed for it.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous, active-high reset
//   in         incoming flit
//   in_valid   in carries a flit
//   in_avail   block accepts a flit this cycle
//   out        N flits packed, port i at [FLIT_SIZE*i +: FLIT_SIZE], 0 when empty
//   out_valid  port i FIFO non-empty
//   out_avail  downstream port i accepts this cycle
//   drop_err   one-cycle pulse, a flit was discarded or a packet was cut short
module one_to_n_distributor #(
    parameter int FLIT_SIZE  = 16,
    parameter int HEADER_LEN = 2,
    parameter logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b10,
    parameter logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b00,
    parameter logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b01,
    parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11,
    parameter int N          = 6,
    parameter int DST_W      = 3,
    parameter int DST_POS    = FLIT_SIZE - HEADER_LEN - 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_SIZE-1:0]   in,
    input  logic                   in_valid,
    output logic                   in_avail,
    output logic [FLIT_SIZE*N-1:0] out,
    output logic [N-1:0]           out_valid,
    input  logic [N-1:0]           out_avail,
    output logic                   drop_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [DST_W:0]     N_EXT    = (DST_W + 1)'(N);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                  state, state_nxt;
    logic [DST_W-1:0]        cur, cur_nxt;
    logic [FLIT_SIZE-1:0]    slot;
    logic                    slot_valid;
    logic                    slot_pop;

    logic [HEADER_LEN-1:0]   slot_type;
    logic [DST_W-1:0]        dst;
    logic                    dst_ok;
    logic                    is_hs;
    logic                    push_en;
    logic                    discard;
    logic                    err;
    logic [DST_W-1:0]        target;
    logic                    target_ready;

    logic [FLIT_SIZE-1:0]    mem    [N][FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr [N];
    logic [PTR_W-1:0]        wr_ptr [N];
    logic [CNT_W-1:0]        cnt    [N];
    logic [N-1:0]            pop;
    logic [N-1:0]            push;
    logic [N-1:0]            can_push;

    assign slot_type = slot[FLIT_SIZE-1 -: HEADER_LEN];
    assign dst       = slot[DST_POS -: DST_W];
    assign dst_ok    = {1'b0, dst} < N_EXT;
    assign is_hs     = (slot_type == HEAD_FLIT) || (slot_type == SINGLE_FLIT);

    // Per-port FIFO status. A full FIFO may still take a push in the same
    // cycle it is being drained, which keeps a streaming port at full rate.
    always_comb begin
        out       = '0;
        out_valid = '0;
        pop       = '0;
        can_push  = '0;
        for (int i = 0; i < N; i++) begin
            out_valid[i] = (cnt[i] != '0);
            pop[i]       = out_valid[i] && out_avail[i];
            can_push[i]  = (cnt[i] != CNT_FULL) || pop[i];
            if (out_valid[i]) begin
                out[FLIT_SIZE*i +: FLIT_SIZE] = mem[i][rd_ptr[i]];
            end
        end
    end

    // Routing decision for the flit in the slot. A HEAD or SINGLE arriving
    // while a packet is still open closes that packet with an error and is
    // then treated exactly as if the FSM were idle, within the same cycle.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        push_en   = 1'b0;
        discard   = 1'b0;
        err       = 1'b0;
        target    = dst;
        case (state)
            DROP: begin
                discard = 1'b1;
                if (slot_type == TAIL_FLIT) state_nxt = IDLE;
            end
            ROUTE: begin
                if (slot_type == BODY_FLIT || slot_type == TAIL_FLIT) begin
                    push_en = 1'b1;
                    target  = cur;
                    if (slot_type == TAIL_FLIT) state_nxt = IDLE;
                end else begin
                    err = 1'b1;
                end
            end
            default: ;
        endcase
        if (state == IDLE || (state == ROUTE && is_hs)) begin
            state_nxt = IDLE;
            if (is_hs) begin
                if (dst_ok) begin
                    push_en = 1'b1;
                    target  = dst;
                    if (slot_type == HEAD_FLIT) begin
                        state_nxt = ROUTE;
                        cur_nxt   = dst;
                    end
                end else begin
                    discard = 1'b1;
                    err     = 1'b1;
                    if (slot_type == HEAD_FLIT) state_nxt = DROP;
                end
            end else begin
                discard = 1'b1;
                err     = 1'b1;
            end
        end
    end

    // The slot only leaves when its own target can take it; a locked route
    // never spills to another port even while that port is full.
    always_comb begin
        target_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (target == DST_W'(i)) target_ready = can_push[i];
        end
        slot_pop = slot_valid && (discard || (push_en && target_ready));
        push     = '0;
        for (int i = 0; i < N; i++) begin
            push[i] = slot_pop && push_en && (target == DST_W'(i));
        end
    end

    assign in_avail = !rst && (!slot_valid || slot_pop);

    // Input slot: a one-flit holding register in front of the router logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot       <= '0;
            slot_valid <= 1'b0;
        end else if (in_valid && in_avail) begin
            slot       <= in;
            slot_valid <= 1'b1;
        end else if (slot_pop) begin
            slot_valid <= 1'b0;
        end
    end

    // Packet FSM; it only advances when the slot actually empties, so a
    // stalled flit is re-evaluated against the same state next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= '0;
            drop_err <= 1'b0;
        end else begin
            drop_err <= slot_pop && err;
            if (slot_pop) begin
                state <= state_nxt;
                cur   <= cur_nxt;
            end
        end
    end

    // Output FIFOs, each a circular buffer with an occupancy counter.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end else begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= slot;
                    wr_ptr[i] <= (wr_ptr[i] == PTR_LAST) ? '0 : wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= (rd_ptr[i] == PTR_LAST) ? '0 : rd_ptr[i] + 1'b1;
                end
                cnt[i] <= cnt[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

endmodule

// File: tb/tb_one_to_n_distributor.sv
// tb_one_to_n_distributor
// Directed bench for one_to_n_distributor. Every accepted flit is run through
// a small packet model that predicts its port (or a drop); predicted flits are
// queued per port and compared whenever the DUT hands a flit downstream.
module tb_one_to_n_distributor;

    localparam int FS = 16;
    localparam int NP = 6;
    localparam logic [1:0] HEAD   = 2'b10;
    localparam logic [1:0] BODY   = 2'b00;
    localparam logic [1:0] TAIL   = 2'b01;
    localparam logic [1:0] SINGLE = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [FS-1:0]    flit_in = '0;
    logic             in_valid = 1'b0;
    logic             in_avail;
    logic [FS*NP-1:0] out;
    logic [NP-1:0]    out_valid;
    logic [NP-1:0]    out_avail = '1;
    logic             drop_err;

    int checks = 0;
    int passes = 0;
    int drop_cnt = 0;
    int exp_drop = 0;

    logic [FS-1:0] exp_q [NP][$];

    typedef enum {M_IDLE, M_ROUTE, M_DROP} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_cur = 0;

    one_to_n_distributor dut (
        .clk       (clk),
        .rst       (rst),
        .in        (flit_in),
        .in_valid  (in_valid),
        .in_avail  (in_avail),
        .out       (out),
        .out_valid (out_valid),
        .out_avail (out_avail),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    function automatic logic [FS-1:0] mk(input logic [1:0] t, input logic [2:0] d,
                                         input logic [10:0] p);
        return {t, d, p};
    endfunction

    // Single comparison point: counts and reports through an immediate assertion.
    task automatic checkOutput(input string tag, input logic [127:0] obs,
                               input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference packet model: decides where an accepted flit should end up.
    task automatic modelAccept(input logic [FS-1:0] f);
        logic [1:0] t;
        int         d;
        bit         e;
        bit         as_idle;
        t = f[15:14];
        d = int'(f[13:11]);
        e = 0;
        as_idle = 0;
        if (m_state == M_DROP) begin
            if (t == TAIL) m_state = M_IDLE;
        end else if (m_state == M_ROUTE) begin
            if (t == BODY) exp_q[m_cur].push_back(f);
            else if (t == TAIL) begin
                exp_q[m_cur].push_back(f);
                m_state = M_IDLE;
            end else begin
                e = 1;
                m_state = M_IDLE;
                as_idle = 1;
            end
        end else begin
            as_idle = 1;
        end
        if (as_idle) begin
            if (t == HEAD || t == SINGLE) begin
                if (d < NP) begin
                    exp_q[d].push_back(f);
                    if (t == HEAD) begin
                        m_state = M_ROUTE;
                        m_cur = d;
                    end
                end else begin
                    e = 1;
                    if (t == HEAD) m_state = M_DROP;
                end
            end else begin
                e = 1;
            end
        end
        if (e) exp_drop++;
    endtask

    // Offers one flit and waits (bounded) for the DUT to take it.
    task automatic applyStimulus(input logic [FS-1:0] f);
        bit acc;
        acc = 0;
        flit_in  = f;
        in_valid = 1'b1;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = in_avail;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("flit_accepted", 128'(acc), 128'd1);
        if (acc) modelAccept(f);
    endtask

    task automatic waitDrain(input string tag);
        int left;
        left = 0;
        for (int c = 0; c < 200; c++) begin
            left = 0;
            for (int i = 0; i < NP; i++) left += exp_q[i].size();
            if (left == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput({tag, "_drained"}, 128'(left), 128'd0);
        checkOutput({tag, "_drop_count"}, 128'(drop_cnt), 128'(exp_drop));
    endtask

    // Output monitor: every visible flit must have been predicted, every
    // handed-over flit must match the prediction, idle slices must read 0.
    always @(negedge clk) begin
        if (!rst) begin
            if (drop_err) drop_cnt++;
            for (int i = 0; i < NP; i++) begin
                if (out_valid[i]) begin
                    checkOutput($sformatf("port%0d_expected_traffic", i),
                                128'(exp_q[i].size() != 0), 128'd1);
                    if (out_avail[i] && exp_q[i].size() != 0) begin
                        checkOutput($sformatf("port%0d_data", i),
                                    128'(out[FS*i +: FS]), 128'(exp_q[i].pop_front()));
                    end
                end else begin
                    checkOutput($sformatf("port%0d_idle_zero", i),
                                128'(out[FS*i +: FS]), 128'd0);
                end
            end
        end
    end

    initial begin
        logic [FS-1:0]    f;
        logic [FS*NP-1:0] exp_out;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_avail", 128'(in_avail), 128'd0);
        checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("reset_out", 128'(out), 128'd0);
        checkOutput("reset_drop_err", 128'(drop_err), 128'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_avail", 128'(in_avail), 128'd1);
        @(posedge clk);
        #1;

        // SINGLE to port 3, latency of two edges
        $display("[TB] single flit to port 3");
        f = mk(SINGLE, 3'd3, 11'h155);
        applyStimulus(f);
        checkOutput("single_not_yet_visible", 128'(out_valid), 128'd0);
        @(posedge clk);
        #1;
        exp_out = '0;
        exp_out[FS*3 +: FS] = f;
        checkOutput("single_out_valid", 128'(out_valid), 128'b001000);
        checkOutput("single_out_vector", 128'(out), 128'(exp_out));
        waitDrain("single");

        // Back-to-back packet to port 1, TAIL carries a misleading dst field
        $display("[TB] 4-flit packet to port 1");
        applyStimulus(mk(HEAD, 3'd1, 11'h001));
        applyStimulus(mk(BODY, 3'd0, 11'h002));
        applyStimulus(mk(BODY, 3'd6, 11'h003));
        applyStimulus(mk(TAIL, 3'd4, 11'h004));
        waitDrain("packet_port1");

        // Backpressure on port 2
        $display("[TB] backpressure on port 2");
        out_avail[2] = 1'b0;
        applyStimulus(mk(HEAD, 3'd2, 11'h010));
        applyStimulus(mk(BODY, 3'd2, 11'h011));
        applyStimulus(mk(BODY, 3'd2, 11'h012));
        flit_in  = mk(TAIL, 3'd2, 11'h013);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stall_in_avail_low", 128'(in_avail), 128'd0);
        end
        @(posedge clk);
        #1;
        out_avail[2] = 1'b1;
        applyStimulus(mk(TAIL, 3'd2, 11'h013));
        applyStimulus(mk(SINGLE, 3'd0, 11'h020));
        waitDrain("backpressure");

        // Out-of-range HEAD: whole packet dropped with a single pulse
        $display("[TB] dropped packet to dst 7");
        applyStimulus(mk(HEAD, 3'd7, 11'h030));
        applyStimulus(mk(BODY, 3'd1, 11'h031));
        applyStimulus(mk(TAIL, 3'd1, 11'h032));
        applyStimulus(mk(SINGLE, 3'd0, 11'h033));
        waitDrain("drop_packet");
        checkOutput("drop_packet_pulses", 128'(drop_cnt), 128'd1);

        // Orphan BODY, then a HEAD that cuts an open packet short
        $display("[TB] orphan body and framing violation");
        applyStimulus(mk(BODY, 3'd3, 11'h040));
        applyStimulus(mk(HEAD, 3'd2, 11'h041));
        applyStimulus(mk(BODY, 3'd2, 11'h042));
        applyStimulus(mk(HEAD, 3'd5, 11'h043));
        applyStimulus(mk(BODY, 3'd0, 11'h044));
        applyStimulus(mk(TAIL, 3'd0, 11'h045));
        waitDrain("framing");
        checkOutput("framing_pulses", 128'(drop_cnt), 128'd3);

        // Reset in the middle of a buffered packet
        $display("[TB] reset mid-packet");
        out_avail[1] = 1'b0;
        applyStimulus(mk(HEAD, 3'd1, 11'h050));
        applyStimulus(mk(BODY, 3'd1, 11'h051));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NP; i++) exp_q[i].delete();
        m_state = M_IDLE;
        @(posedge clk);
        #1;
        checkOutput("midreset_out_valid", 128'(out_valid), 128'd0);
        checkOutput("midreset_in_avail", 128'(in_avail), 128'd0);
        checkOutput("midreset_out", 128'(out), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_avail = '1;
        #1;
        checkOutput("release_in_avail", 128'(in_avail), 128'd1);
        applyStimulus(mk(SINGLE, 3'd0, 11'h060));
        waitDrain("after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
